// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial two's-complement subtractor. Computes
//             diff = a - b - bin one bit per clock, LSB first, through a
//             single full-subtractor cell with a registered borrow.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset
//    start  in   1      request; sampled only in IDLE or DONE
//    a      in   WIDTH  minuend, captured on accepted start
//    b      in   WIDTH  subtrahend, captured on accepted start
//    bin    in   1      borrow-in, captured on accepted start
//    busy   out  1      high while bits are being processed (SHIFT)
//    done   out  1      one-cycle pulse when a result is complete
//    diff   out  WIDTH  last completed difference
//    bout   out  1      borrow-out of the MSB (unsigned a < b + bin)
//    ovf    out  1      signed overflow of the last result
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q,  a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,  b_sr_d;
  logic [WIDTH-1:0]   work_q,  work_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               br_q,    br_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [WIDTH-1:0]   diff_q,  diff_d;
  logic               bout_q,  bout_d;
  logic               ovf_q,   ovf_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic a_bit;
  logic b_bit;
  logic diff_bit;
  logic br_next;

  assign a_bit    = a_sr_q[0];
  assign b_bit    = b_sr_q[0];
  assign diff_bit = a_bit ^ b_bit ^ br_q;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        busy_d = 1'b1;
        // Result bits enter at the MSB so that after WIDTH shifts the first
        // (LSB) difference bit has reached position 0.
        work_d = {diff_bit, work_q[WIDTH-1:1]};
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {diff_bit, work_q[WIDTH-1:1]};
          bout_d  = br_next;
          // On the MSB cycle br_q is the borrow into the sign bit and
          // br_next the borrow out; they differ exactly on signed overflow.
          ovf_d   = br_q ^ br_next;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done.
  // lat = cycles from the accepting edge until done is seen (expected 9),
  // bcnt = cycles busy was observed high before done.
  task automatic run_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic bb_in, output int lat, output int bcnt);
    a = aa; b = bb; bin = bb_in; start = 1'b1;
    tick();
    start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 50) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_op(8'h5A, 8'h3C, 1'b0, lat, bcnt);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
    checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    checks++; if (diff !== 8'h1E) begin errors++; $display("FAIL basic_diff got %h want 1e", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %b want 0", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (diff !== 8'h1E) begin errors++; $display("FAIL basic_diff_hold got %h want 1e", diff); end
  endtask

  task automatic test_borrow_ovf();
    int lat, bcnt;
    run_op(8'h00, 8'h01, 1'b0, lat, bcnt);
    checks++; if (lat !== 9) begin errors++; $display("FAIL borrow_latency got %0d want 9", lat); end
    checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL borrow_diff got %h want ff", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL borrow_bout got %b want 1", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL borrow_ovf got %b want 0", ovf); end
    tick();
    run_op(8'h80, 8'h01, 1'b0, lat, bcnt);
    checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL ovf_diff got %h want 7f", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL ovf_bout got %b want 0", bout); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_ovf got %b want 1", ovf); end
    tick();
  endtask

  task automatic test_borrow_in();
    int lat, bcnt;
    run_op(8'h10, 8'h0F, 1'b1, lat, bcnt);
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL bin_diff got %h want 00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL bin_bout got %b want 0", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bin_ovf got %b want 0", ovf); end
    tick();
    // Result stays 0 but borrow-out flips: distinguishes bin handling.
    run_op(8'h00, 8'hFF, 1'b1, lat, bcnt);
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL bin_wrap_diff got %h want 00", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL bin_wrap_bout got %b want 1", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bin_wrap_ovf got %b want 0", ovf); end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra_done;
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    tick();                       // accepting edge; SHIFT cycle 1
    start = 1'b0;
    tick();                       // SHIFT cycle 2
    tick();                       // SHIFT cycle 3
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", busy); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL ign_diff_prior got %h want 00", diff); end
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 50) begin
      a = ~a; b = ~b;
      tick();
      lat++;
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency got %0d want 9", lat); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL ign_diff got %h want 02", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL ign_bout got %b want 0", bout); end
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) extra_done++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL ign_extra_done got %0d want 0", extra_done); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL ign_diff_hold got %h want 02", diff); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    int   n_done;
    a = 8'h20; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    n_done = 0;
    for (int k = 1; k <= 27; k++) begin
      exp_done = ((k % 9) == 0);
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, exp_done);
      end
      checks++;
      if (busy !== !exp_done) begin
        errors++; $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, !exp_done);
      end
      if (done) begin
        n_done++;
        checks++;
        if (diff !== 8'h1F) begin errors++; $display("FAIL b2b_diff k=%0d got %h want 1f", k, diff); end
      end
      if (k == 27) start = 1'b0;
      tick();
    end
    checks++; if (n_done !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, n_done;
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    tick();                       // SHIFT cycle 1
    start = 1'b0;
    repeat (3) tick();            // SHIFT cycle 4
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL rmid_diff got %h want 00", diff); end
    checks++; if ({done, bout, ovf} !== 3'b000) begin errors++; $display("FAIL rmid_flags got %b want 000", {done, bout, ovf}); end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", n_done); end
    run_op(8'h5A, 8'h3C, 1'b0, lat, bcnt);
    checks++; if (lat !== 9) begin errors++; $display("FAIL rmid_latency got %0d want 9", lat); end
    checks++; if (diff !== 8'h1E) begin errors++; $display("FAIL rmid_diff_after got %h want 1e", diff); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_borrow_in();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
